cha_map: RTL
============

# cha_map

Clocked, parametrised successor to the MVS CHA CPLD address mapper. It samples the NEO-GEO PBUS on PCK1B/PCK2B edges and builds the C-ROM (sprite) and S-ROM (fix) flash addresses. It relocates each game into a flash bank selected by GSEL, using a per-game IX offset and MASK. It generalises the chip count, and adds a game-switch state machine that blanks all flash output enables while GSEL changes and settles.

## Interface
Parameters:
- CHIP_AW, 27, address width of one C flash chip (word address).
- NCHIPS, 2, number of C flash chips; power of two, ≥2. CSW = log2(NCHIPS).
- IX_W, CHIP_AW+1+CSW-18, width of the bank offset IX.
- S_AW, 17, S_ADDR width.
- SETTLE, 16, number of stable GSEL cycles required before commit; range 1..255.

Ports:
- CLK  in  1  system clock; at least 8× the CA4 toggle rate.
- nRESET  in  1  asynchronous, active-low reset.
- PBUS  in  23  multiplexed address bus.
- PCK1B, PCK2B  in  1  C and S latch strobes; asynchronous to CLK.
- CA4, S2H1  in  1  C and S low address bits; asynchronous to CLK.
- GSEL  in  8  game select; 0 = no game.
- C_ADDR  out  CHIP_AW  per-chip C address.
- C_nOE  out  2*NCHIPS  active-low output enables, two halves per chip.
- S_ADDR  out  S_AW  fix address.
- READY  out  1  high in RUN.

## Operation
- **Input synchronisation:** PCK1B, PCK2B, CA4, S2H1 and GSEL each pass through a 2-FF synchroniser.
- **PCK1B rise:** C_LAT[22:0] ← PBUS[22:0].
- **PCK2B rise:** S_LAT[15:0] ← PBUS[15:0].
- **Linear C address (24 bits):** CA = {C_LAT[22:20]&MASK[5:3], C_LAT[19:17]&MASK[2:0], C_LAT[16:4], CA4s, C_LAT[3:0]}.
- **Full C address:** FULL = {(IX + CA[23:18]) mod 2^IX_W, CA[17:0]}.
  - C_ADDR = FULL[CHIP_AW-1:0].
  - Half select h = FULL[CHIP_AW].
  - Chip select c = FULL[CHIP_AW+CSW:CHIP_AW+1].
  - In RUN: C_nOE[2c+h] = 0; all other bits = 1.
- **S address:** S_ADDR = {S_LAT[15:3], S2Hs, S_LAT[2:0]}. It is unaffected by MASK and IX; the GSEL bank is applied by hardware.
- **Table:** (MASK, IX) = f(GSEL_A), where GSEL_A is the committed GSEL. Unlisted GSEL values give MASK = 6'h3F, IX = 0.
- **FSM states:** IDLE, BLANK, SETTLE, RUN.
  - IDLE: GSELs = 0. Latches are cleared and held; C_nOE is all 1.
    - GSELs ≠ 0 → SETTLE, counter ← SETTLE-1.
  - RUN: GSELs ≠ GSEL_A → BLANK.
  - BLANK: lasts exactly 1 cycle; C_nOE all 1 → SETTLE, counter ← SETTLE-1.
  - SETTLE: C_nOE all 1. Latches keep updating.
    - If GSELs changes, the counter reloads.
    - If GSELs = 0 → IDLE.
    - If counter = 0: GSEL_A ← GSELs, MASK/IX loaded → RUN.
- **Simultaneous events:** if a PCK1B edge and a GSEL commit fall in the same cycle, the latch update and the commit both take effect. The first RUN-cycle address uses the new latch and the new IX.
- **Reset values:** C_ADDR = 0, S_ADDR = 0, C_nOE all 1, READY = 0, state IDLE, GSEL_A = 0, MASK = 6'h3F, IX = 0, latches = 0.
- **Reset mid-operation:** all outputs take their reset values immediately and asynchronously.

## Timing
- Strobe edge → latch updated: 3 CLK (2 sync + edge detect).
- Latch, CA4s or S2Hs change → C_ADDR, S_ADDR and C_nOE registered: 1 CLK more.
  - Pin CA4 → C_ADDR: 4 CLK.
- GSEL step → C_nOE all 1: 3 CLK (2 sync + BLANK entry).
- READY rises 2 + 1 + SETTLE + 1 CLK after the last GSEL change (BLANK path).
- The IX addition wraps modulo 2^IX_W with no carry out.
- Strobe pulses narrower than 2 CLK are not guaranteed to be captured.

## Structure
- **Package cha_pkg:** FSM state encoding, MASK default 6'h3F, IX default 0, derived-width functions (CSW, IX_W).
- **Sub-module cha_ix_table:** combinational GSEL → {MASK, IX}, filled from the per-game include file.
- **cha_map itself:** synchronisers, latches, FSM and output registers.

## Test plan
- **Reset:** assert nRESET low mid-RUN → C_nOE = 4'b1111, READY = 0, C_ADDR = 0 within the same cycle.
- **Switch-in:** GSEL 0 → 5 (IX = 0x002, MASK = 6'h3F), PBUS = 0x000010 on PCK1B, CA4 = 1.
  - READY after 3+SETTLE CLK.
  - FULL = 0x0080030 → C_ADDR = 27'h0080030, C_nOE = 4'b1110.
- **Wrap-around:** IX = 0x7FF, PBUS[22:17] = 6'h3F → sum 0x03E; C_ADDR[26:18] = 9'h03E, C_nOE = 4'b1110.
- **Mask:** MASK = 6'b000111, PBUS[22:20] = 3'b111 → CA[23:21] = 0.
- **Chip/half select:** IX = 0x600, CA[23:18] = 0 → c = 1, h = 1, C_nOE = 4'b0111.
- **GSEL glitch:** GSEL toggles 5→6→5 within SETTLE/2 cycles.
  - C_nOE stays all 1 and the counter restarts.
  - Commit is GSEL_A = 5, SETTLE cycles after the last change.
  - S_ADDR keeps tracking PCK2B throughout.

Source files
------------

// File: rtl/cha_pkg.sv
// Shared types and constants for the CHA C/S-ROM address mapper.
package cha_pkg;

    // Game-switch state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } cha_state_e;

    // Bank placement used when no game entry applies
    localparam logic [5:0]  MASK_DEF = 6'h3F;
    localparam int unsigned IX_DEF   = 0;

    // Number of chip-select bits for a given flash chip count
    function automatic int cha_csw(input int nchips);
        return $clog2(nchips);
    endfunction

    // Width of the per-game bank offset: spans everything above the 18 fixed CA bits
    function automatic int cha_ix_w(input int chip_aw, input int nchips);
        return chip_aw + 1 + cha_csw(nchips) - 18;
    endfunction

endpackage

// File: rtl/cha_ix_table.sv
// Per-game bank table: maps a committed game number to its CA mask and bank offset.
module cha_ix_table
    import cha_pkg::*;
#(
    parameter int IX_W = 11
) (
    input  logic [7:0]      gsel,
    output logic [5:0]      mask,
    output logic [IX_W-1:0] ix
);

    // Game placement lookup; unlisted games fall back to full mask and no offset
    always_comb begin
        mask = MASK_DEF;
        ix   = IX_W'(IX_DEF);
        case (gsel)
            8'd1: begin mask = 6'h07; ix = IX_W'(11'h010); end
            8'd2: begin mask = 6'h3F; ix = IX_W'(11'h040); end
            8'd5: begin mask = 6'h3F; ix = IX_W'(11'h002); end
            8'd6: begin mask = 6'h3F; ix = IX_W'(11'h7FF); end
            8'd7: begin mask = 6'h07; ix = IX_W'(11'h000); end
            8'd8: begin mask = 6'h3F; ix = IX_W'(11'h600); end
            default: begin mask = MASK_DEF; ix = IX_W'(IX_DEF); end
        endcase
    end

endmodule

// File: rtl/cha_map.sv
// CHA address mapper: samples the PBUS on the C/S latch strobes, relocates the
// sprite address into the flash bank of the selected game, and blanks every
// flash output enable while the game selection changes and settles.
module cha_map
    import cha_pkg::*;
#(
    parameter int CHIP_AW = 27,
    parameter int NCHIPS  = 2,
    parameter int S_AW    = 17,
    parameter int SETTLE  = 16
) (
    input  logic                CLK,
    input  logic                nRESET,
    input  logic [22:0]         PBUS,
    input  logic                PCK1B,
    input  logic                PCK2B,
    input  logic                CA4,
    input  logic                S2H1,
    input  logic [7:0]          GSEL,
    output logic [CHIP_AW-1:0]  C_ADDR,
    output logic [2*NCHIPS-1:0] C_nOE,
    output logic [S_AW-1:0]     S_ADDR,
    output logic                READY
);

    localparam int CSW  = cha_csw(NCHIPS);
    localparam int IX_W = cha_ix_w(CHIP_AW, NCHIPS);
    localparam int FW   = CHIP_AW + 1 + CSW;
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

    // Synchroniser chains; the third stage of the strobes serves edge detection,
    // the third stage of CA4/S2H1 keeps them aligned with freshly latched data.
    logic [2:0]      pck1_r;
    logic [2:0]      pck2_r;
    logic [2:0]      ca4_r;
    logic [2:0]      s2h_r;
    logic [7:0]      gsel_meta_r;
    logic [7:0]      gsel_sync_r;
    logic [7:0]      gsel_prev_r;

    logic            pck1_rise_s;
    logic            pck2_rise_s;
    logic            ca4_s;
    logic            s2h_s;
    logic [7:0]      gsel_s;

    cha_state_e      state_r;
    cha_state_e      state_n;
    logic [7:0]      cnt_r;
    logic [7:0]      cnt_n;
    logic            commit_s;

    logic [7:0]      gsel_a_r;
    logic [5:0]      mask_r;
    logic [IX_W-1:0] ix_r;
    logic [5:0]      tbl_mask_s;
    logic [IX_W-1:0] tbl_ix_s;

    logic [22:0]     c_lat_r;
    logic [15:0]     s_lat_r;

    logic [23:0]     ca_s;
    logic [IX_W-1:0] bank_s;
    logic [FW-1:0]   full_s;
    logic [CSW:0]    sel_s;
    logic [2*NCHIPS-1:0] dec_s;
    logic [16:0]     s_full_s;

    assign pck1_rise_s = pck1_r[1] & ~pck1_r[2];
    assign pck2_rise_s = pck2_r[1] & ~pck2_r[2];
    assign ca4_s       = ca4_r[2];
    assign s2h_s       = s2h_r[2];
    assign gsel_s      = gsel_sync_r;

    cha_ix_table #(
        .IX_W (IX_W)
    ) u_ix_table (
        .gsel (gsel_s),
        .mask (tbl_mask_s),
        .ix   (tbl_ix_s)
    );

    // Bring the asynchronous PBUS strobes, low address bits and game select into CLK
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            pck1_r      <= 3'b000;
            pck2_r      <= 3'b000;
            ca4_r       <= 3'b000;
            s2h_r       <= 3'b000;
            gsel_meta_r <= 8'd0;
            gsel_sync_r <= 8'd0;
            gsel_prev_r <= 8'd0;
        end else begin
            pck1_r      <= {pck1_r[1:0], PCK1B};
            pck2_r      <= {pck2_r[1:0], PCK2B};
            ca4_r       <= {ca4_r[1:0], CA4};
            s2h_r       <= {s2h_r[1:0], S2H1};
            gsel_meta_r <= GSEL;
            gsel_sync_r <= gsel_meta_r;
            gsel_prev_r <= gsel_sync_r;
        end
    end

    // Game-switch sequencing: blank, wait for a stable selection, then commit it
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        commit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gsel_s != 8'd0) begin
                    state_n = ST_SETTLE;
                    cnt_n   = SETTLE_LOAD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_BLANK: begin
                state_n = ST_SETTLE;
                cnt_n   = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (gsel_s == 8'd0) begin
                    state_n = ST_IDLE;
                end else if (gsel_s != gsel_prev_r) begin
                    cnt_n = SETTLE_LOAD;
                end else if (cnt_r == 8'd0) begin
                    state_n  = ST_RUN;
                    commit_s = 1'b1;
                end else begin
                    cnt_n = cnt_r - 8'd1;
                end
            end
            ST_RUN: begin
                if (gsel_s != gsel_a_r) begin
                    state_n = ST_BLANK;
                end else begin
                    state_n = ST_RUN;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 8'd0;
            end
        endcase
    end

    // State, settle counter and the committed game with its bank placement
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 8'd0;
            gsel_a_r <= 8'd0;
            mask_r   <= MASK_DEF;
            ix_r     <= IX_W'(IX_DEF);
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            if (commit_s) begin
                gsel_a_r <= gsel_s;
                mask_r   <= tbl_mask_s;
                ix_r     <= tbl_ix_s;
            end
        end
    end

    // PBUS latches: cleared and frozen with no game selected, live otherwise
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            c_lat_r <= 23'd0;
            s_lat_r <= 16'd0;
        end else if (state_r == ST_IDLE) begin
            c_lat_r <= 23'd0;
            s_lat_r <= 16'd0;
        end else begin
            if (pck1_rise_s) begin
                c_lat_r <= PBUS;
            end
            if (pck2_rise_s) begin
                s_lat_r <= PBUS[15:0];
            end
        end
    end

    // Address build: mask the game-relative CA, add the bank offset, decode chip/half
    always_comb begin
        ca_s     = {c_lat_r[22:20] & mask_r[5:3],
                    c_lat_r[19:17] & mask_r[2:0],
                    c_lat_r[16:4], ca4_s, c_lat_r[3:0]};
        bank_s   = ix_r + IX_W'(ca_s[23:18]);
        full_s   = {bank_s, ca_s[17:0]};
        sel_s    = full_s[FW-1:CHIP_AW];
        dec_s    = '1;
        dec_s[sel_s] = 1'b0;
        s_full_s = {s_lat_r[15:3], s2h_s, s_lat_r[2:0]};
    end

    // Output registers; enables open only once RUN has been held for a full
    // cycle so the address they qualify already reflects the committed bank
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            C_ADDR <= '0;
            S_ADDR <= '0;
            C_nOE  <= '1;
            READY  <= 1'b0;
        end else begin
            C_ADDR <= full_s[CHIP_AW-1:0];
            S_ADDR <= S_AW'(s_full_s);
            READY  <= (state_n == ST_RUN);
            if ((state_r == ST_RUN) && (state_n == ST_RUN)) begin
                C_nOE <= dec_s;
            end else begin
                C_nOE <= '1;
            end
        end
    end

endmodule
